// File: rtl/channel_in_pass_acc.sv
// Per-pixel partial-sum accumulator across input-channel passes of one output tile.
// Buffers intermediate sums locally and emits the final per-pixel sum on the last pass.
module channel_in_pass_acc #(
   parameter int PICTURE_NUM = 8,
   parameter int LANE_W      = 32,
   parameter int DEPTH       = 256,
   parameter int AW          = 8,
   parameter int PW          = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [AW-1:0]                 cfg_pixel_last,
   input  logic [PW-1:0]                 cfg_pass_last,
   input  logic [PICTURE_NUM*LANE_W-1:0] data_in,
   input  logic                          data_in_valid,
   output logic [PICTURE_NUM*LANE_W-1:0] data_out,
   output logic                          data_out_valid,
   output logic                          busy,
   output logic                          done
);

   // state | meaning
   // IDLE  | waiting for start; cfg latched on start
   // ACC   | accepting beats, accumulating passes
   // DONE  | one cycle after the final beat, then back to IDLE
   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

   localparam int DW = PICTURE_NUM * LANE_W;

   state_t          state, state_nxt;
   logic [AW-1:0]   pixel_last_q;
   logic [PW-1:0]   pass_last_q;
   logic [AW-1:0]   pix_cnt;
   logic [PW-1:0]   pass_cnt;
   logic [DW-1:0]   mem [DEPTH];
   logic [DW-1:0]   rd_data;
   logic [DW-1:0]   sum;
   logic            beat;
   logic            last_pix;
   logic            last_pass;
   logic            start_ok;

   always_comb begin
      start_ok  = (state == S_IDLE) && start;
      beat      = (state == S_ACC) && data_in_valid;
      last_pix  = (pix_cnt == pixel_last_q);
      last_pass = (pass_cnt == pass_last_q);
      busy      = (state == S_ACC);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_ACC;
         S_ACC:   if (beat && last_pix && last_pass) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Combinational read so a same-address RMW on consecutive beats sees the prior write.
   always_comb begin
      rd_data = mem[pix_cnt];
      sum     = '0;
      for (int k = 0; k < PICTURE_NUM; k++) begin
         sum[k*LANE_W +: LANE_W] = ((pass_cnt == '0) ? '0 : rd_data[k*LANE_W +: LANE_W])
                                   + data_in[k*LANE_W +: LANE_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         pixel_last_q   <= '0;
         pass_last_q    <= '0;
         pix_cnt        <= '0;
         pass_cnt       <= '0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         done           <= 1'b0;
      end else begin
         state          <= state_nxt;
         data_out_valid <= 1'b0;
         done           <= (state == S_DONE);
         if (start_ok) begin
            pixel_last_q <= cfg_pixel_last;
            pass_last_q  <= cfg_pass_last;
            pix_cnt      <= '0;
            pass_cnt     <= '0;
         end else if (beat) begin
            if (last_pix) begin
               pix_cnt  <= '0;
               pass_cnt <= pass_cnt + 1'b1;
            end else begin
               pix_cnt <= pix_cnt + 1'b1;
            end
            if (last_pass) begin
               data_out       <= sum;
               data_out_valid <= 1'b1;
            end
         end
      end
   end

   // Buffer has no reset: pass 0 always overwrites whatever is left.
   always_ff @(posedge clk) begin
      if (!rst && beat && !last_pass)
         mem[pix_cnt] <= sum;
   end

endmodule

// File: tb/tb_channel_in_pass_acc.sv
// Directed bench for channel_in_pass_acc with hand-computed expectations and a small
// accumulation model for the randomized gappy-valid tile.
module tb_channel_in_pass_acc;

   logic         clk;
   logic         rst;
   logic         start;
   logic [7:0]   cfg_pixel_last;
   logic [9:0]   cfg_pass_last;
   logic [255:0] data_in;
   logic         data_in_valid;
   logic [255:0] data_out;
   logic         data_out_valid;
   logic         busy;
   logic         done;

   int vectors = 0;
   int errors  = 0;

   channel_in_pass_acc dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .cfg_pixel_last (cfg_pixel_last),
      .cfg_pass_last  (cfg_pass_last),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .busy           (busy),
      .done           (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [255:0] d);
      data_in       = d;
      data_in_valid = 1'b1;
      tick();
      data_in_valid = 1'b0;
   endtask

   task automatic do_start(input logic [7:0] pl, input logic [9:0] ql);
      cfg_pixel_last = pl;
      cfg_pass_last  = ql;
      start          = 1'b1;
      tick();
      start          = 1'b0;
      cfg_pixel_last = 8'hAA;
      cfg_pass_last  = 10'h155;
   endtask

   logic [255:0] d;
   logic [255:0] e;
   logic [31:0]  m [8][8];
   logic [31:0]  r;

   initial begin
      rst = 1'b1; start = 1'b0; cfg_pixel_last = '0; cfg_pass_last = '0;
      data_in = '0; data_in_valid = 1'b0;
      tick(); tick();
      chk("rst_valid", data_out_valid, 0);
      chk("rst_out", data_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      tick();

      // 1: 4 pixels x 3 passes, lane0 = pass*10+pix, lane1 = 100+beat index
      do_start(8'd3, 10'd2);
      chk("t1_busy", busy, 1);
      for (int i = 0; i < 12; i++) begin
         d = '0;
         d[0 +: 32]  = 32'((i / 4) * 10 + (i % 4));
         d[32 +: 32] = 32'(100 + i);
         beat(d);
         chk("t1_valid", data_out_valid, (i >= 8) ? 1 : 0);
         if (i >= 8) begin
            e = '0;
            e[0 +: 32]  = 32'(30 + 3 * (i % 4));
            e[32 +: 32] = 32'(312 + 3 * (i % 4));
            chk("t1_out", data_out, e);
            chk("t1_done_early", done, 0);
         end
      end
      tick();
      chk("t1_done", done, 1);
      chk("t1_valid_after", data_out_valid, 0);
      chk("t1_hold", data_out[31:0], 32'd39);
      chk("t1_busy_after", busy, 0);
      tick();
      chk("t1_done_pulse", done, 0);

      // 2: single pass passthrough
      do_start(8'd1, 10'd0);
      beat({8{32'h7FFFFFFF}});
      chk("t2_valid0", data_out_valid, 1);
      chk("t2_out0", data_out, {8{32'h7FFFFFFF}});
      beat({8{32'hFFFFFFFF}});
      chk("t2_valid1", data_out_valid, 1);
      chk("t2_out1", data_out, {8{32'hFFFFFFFF}});
      tick();
      chk("t2_done", done, 1);
      chk("t2_valid_after", data_out_valid, 0);
      tick();

      // 3: one pixel, two passes, back-to-back RMW with wrap
      do_start(8'd0, 10'd1);
      d = '0; d[0 +: 32] = 32'h7FFFFFFF; d[32 +: 32] = 32'd5; d[64 +: 32] = 32'hFFFFFFFD;
      beat(d);
      chk("t3_valid0", data_out_valid, 0);
      d = '0; d[0 +: 32] = 32'd1; d[32 +: 32] = 32'hFFFFFFF6; d[64 +: 32] = 32'hFFFFFFFC;
      beat(d);
      e = '0; e[0 +: 32] = 32'h80000000; e[32 +: 32] = 32'hFFFFFFFB; e[64 +: 32] = 32'hFFFFFFF9;
      chk("t3_valid1", data_out_valid, 1);
      chk("t3_out", data_out, e);
      tick();
      chk("t3_done", done, 1);
      tick();

      // 4: 8 pixels x 4 passes, one valid beat in three, random lanes vs model
      do_start(8'd7, 10'd3);
      for (int i = 0; i < 32; i++) begin
         tick();
         chk("t4_gap_valid", data_out_valid, 0);
         tick();
         d = '0;
         for (int k = 0; k < 8; k++) begin
            r = $urandom;
            d[k*32 +: 32] = r;
            m[i % 8][k] = (i < 8) ? r : m[i % 8][k] + r;
         end
         beat(d);
         chk("t4_valid", data_out_valid, (i >= 24) ? 1 : 0);
         if (i >= 24) begin
            for (int k = 0; k < 8; k++) e[k*32 +: 32] = m[i % 8][k];
            chk("t4_out", data_out, e);
         end
      end
      tick();
      chk("t4_done", done, 1);
      tick();

      // 5: reset mid pass 1, then a fresh tile over stale buffer contents
      do_start(8'd1, 10'd2);
      beat({8{32'd100}});
      beat({8{32'd200}});
      beat({8{32'd7}});
      rst = 1'b1;
      data_in = {8{32'd9}}; data_in_valid = 1'b1;
      tick();
      chk("t5_rst_out", data_out, 0);
      chk("t5_rst_valid", data_out_valid, 0);
      chk("t5_rst_busy", busy, 0);
      data_in_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("t5_idle_valid", data_out_valid, 0);
      do_start(8'd1, 10'd1);
      beat({8{32'd5}});
      chk("t5_valid0", data_out_valid, 0);
      beat({8{32'd6}});
      chk("t5_valid1", data_out_valid, 0);
      beat({8{32'd1}});
      chk("t5_out0", data_out, {8{32'd6}});
      beat({8{32'd1}});
      chk("t5_out1", data_out, {8{32'd7}});
      chk("t5_valid3", data_out_valid, 1);
      tick();
      chk("t5_done", done, 1);
      tick();

      // 6: start/valid while in ACC and DONE
      do_start(8'd1, 10'd1);
      cfg_pixel_last = 8'd0; cfg_pass_last = 10'd0; start = 1'b1;
      beat({8{32'd10}});
      start = 1'b0;
      chk("t6_acc_start_valid", data_out_valid, 0);
      chk("t6_acc_busy", busy, 1);
      beat({8{32'd20}});
      chk("t6_valid1", data_out_valid, 0);
      beat({8{32'd1}});
      chk("t6_out0", data_out, {8{32'd11}});
      beat({8{32'd2}});
      chk("t6_out1", data_out, {8{32'd22}});
      cfg_pixel_last = 8'd0; cfg_pass_last = 10'd0; start = 1'b1;
      beat({8{32'd999}});
      start = 1'b0;
      chk("t6_done_drop_valid", data_out_valid, 0);
      chk("t6_done_drop_out", data_out, {8{32'd22}});
      chk("t6_done", done, 1);
      chk("t6_done_busy", busy, 0);
      tick();
      chk("t6_idle_busy", busy, 0);
      do_start(8'd1, 10'd1);
      beat({8{32'd3}});
      beat({8{32'd4}});
      beat({8{32'd5}});
      chk("t6_next_out0", data_out, {8{32'd8}});
      beat({8{32'd6}});
      chk("t6_next_out1", data_out, {8{32'd10}});
      tick();
      chk("t6_next_done", done, 1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
